bram_dma_streamer: RTL and testbench



---
 rtl/pdh_capture_pkg.sv | 15 +
 rtl/stream_skid_fifo.sv | 60 ++++++
 rtl/bram_dma_streamer.sv | 148 ++++++++++++++
 tb/tb_bram_dma_streamer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdh_capture_pkg.sv
// Shared definitions for the PDH capture path: streamer FSM states and the
// default capture depth agreed with the capture controller.
package pdh_capture_pkg;

  localparam int CAPTURE_DEPTH = 16_384;
  localparam int AXIS_DW       = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry head/tail FIFO; the head register drives the stream directly so
// valid and data come straight from flops and only change on a pop or push.
module stream_skid_fifo #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         full,
  output logic         empty
);

  logic         head_valid_reg;
  logic [W-1:0] head_data_reg;
  logic         tail_valid_reg;
  logic [W-1:0] tail_data_reg;
  logic         pop_fire;

  assign pop_fire  = head_valid_reg && pop;
  assign out_valid = head_valid_reg;
  assign out_data  = head_data_reg;
  assign full      = tail_valid_reg;
  assign empty     = !head_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid_reg <= 1'b0;
      head_data_reg  <= '0;
      tail_valid_reg <= 1'b0;
      tail_data_reg  <= '0;
    end else if (flush) begin
      head_valid_reg <= 1'b0;
      tail_valid_reg <= 1'b0;
    end else if (pop_fire) begin
      if (tail_valid_reg) begin
        head_data_reg  <= tail_data_reg;
        tail_valid_reg <= push;
        if (push) tail_data_reg <= push_data;
      end else begin
        head_valid_reg <= push;
        if (push) head_data_reg <= push_data;
      end
    end else if (push) begin
      // Writer never pushes into a full FIFO; the read credit prevents it.
      if (!head_valid_reg) begin
        head_valid_reg <= 1'b1;
        head_data_reg  <= push_data;
      end else if (!tail_valid_reg) begin
        tail_valid_reg <= 1'b1;
        tail_data_reg  <= push_data;
      end
    end
  end

endmodule

// File: rtl/bram_dma_streamer.sv
// Streams one completed capture (BRAM words 0..DEPTH-1) out as AXI4-Stream and
// handshakes completion back to the capture controller with a level signal.
module bram_dma_streamer
  import pdh_capture_pkg::*;
#(
  parameter int DEPTH       = CAPTURE_DEPTH,
  parameter int AW          = $clog2(DEPTH),
  parameter int SYNC_STAGES = 2
) (
  input  logic          axi_clk,
  input  logic          rst_ni,
  input  logic          dma_enable_i,
  output logic          dma_termination_o,
  output logic [AW-1:0] bram_addr_o,
  input  logic [63:0]   bram_rdata_i,
  output logic [63:0]   m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic          busy_o
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [SYNC_STAGES-1:0] en_sync_reg;
  logic                   en_d_reg;
  logic                   en_s;
  logic                   en_rise;

  state_t                 state_reg;
  logic [AW-1:0]          addr_reg;
  logic [AW-1:0]          beat_cnt_reg;
  logic                   rd_inflight_reg;
  logic                   rd_last_reg;
  logic                   term_reg;

  logic                   fifo_valid;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [64:0]            fifo_dout;

  logic                   active;
  logic                   abort;
  logic                   beat_fire;
  logic                   last_fire;
  logic                   addr_last;
  logic                   rd_issue;
  logic [1:0]             occupancy;
  logic [2:0]             credit_used;

  // Synchronizer and edge detector reset high so an enable already held
  // across reset is not mistaken for a fresh request.
  always_ff @(posedge axi_clk or negedge rst_ni) begin
    if (!rst_ni) begin
      en_sync_reg <= '1;
      en_d_reg    <= 1'b1;
    end else begin
      en_sync_reg <= {en_sync_reg[SYNC_STAGES-2:0], dma_enable_i};
      en_d_reg    <= en_s;
    end
  end

  assign en_s    = en_sync_reg[SYNC_STAGES-1];
  assign en_rise = en_s && !en_d_reg;

  assign active    = (state_reg == ST_STREAM) || (state_reg == ST_DRAIN);
  assign abort     = active && !en_s;
  assign beat_fire = fifo_valid && m_axis_tready;
  assign last_fire = beat_fire && (beat_cnt_reg == LAST_IDX);
  assign addr_last = (addr_reg == LAST_IDX);

  // Occupancy is taken after this cycle's pop so a ready sink sees no bubbles.
  assign occupancy   = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign credit_used = {1'b0, occupancy} + {2'b00, rd_inflight_reg} - {2'b00, beat_fire};
  assign rd_issue    = (state_reg == ST_STREAM) && en_s && (credit_used < 3'd2);

  always_ff @(posedge axi_clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= ST_IDLE;
      addr_reg        <= '0;
      beat_cnt_reg    <= '0;
      rd_inflight_reg <= 1'b0;
      rd_last_reg     <= 1'b0;
      term_reg        <= 1'b0;
    end else begin
      rd_inflight_reg <= rd_issue;
      rd_last_reg     <= rd_issue && addr_last;
      if (beat_fire) beat_cnt_reg <= beat_cnt_reg + 1'b1;

      case (state_reg)
        ST_IDLE: begin
          term_reg <= 1'b0;
          if (en_rise) begin
            state_reg    <= ST_STREAM;
            addr_reg     <= '0;
            beat_cnt_reg <= '0;
          end
        end
        ST_STREAM: begin
          if (abort) begin
            state_reg <= ST_IDLE;
          end else if (rd_issue) begin
            if (addr_last) state_reg <= ST_DRAIN;
            else           addr_reg  <= addr_reg + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            state_reg <= ST_IDLE;
          end else if (last_fire) begin
            state_reg <= ST_DONE;
            term_reg  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!en_s) begin
            state_reg <= ST_IDLE;
            term_reg  <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  stream_skid_fifo #(
    .W(65)
  ) u_fifo (
    .clk       (axi_clk),
    .rst_n     (rst_ni),
    .flush     (abort),
    .push      (rd_inflight_reg),
    .push_data ({rd_last_reg, bram_rdata_i}),
    .pop       (m_axis_tready),
    .out_valid (fifo_valid),
    .out_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bram_addr_o       = addr_reg;
  assign m_axis_tdata      = fifo_dout[63:0];
  assign m_axis_tvalid     = fifo_valid;
  assign m_axis_tlast      = fifo_valid && fifo_dout[64];
  assign dma_termination_o = term_reg;
  assign busy_o            = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_bram_dma_streamer.sv
// Scoreboard bench: stimulus queues expected beats, a negedge monitor checks
// every accepted beat, tdata stability under backpressure and termination timing.
module tb_bram_dma_streamer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int SS    = 2;

  logic          axi_clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          dma_enable_i = 1'b0;
  logic          dma_termination_o;
  logic [AW-1:0] bram_addr_o;
  logic [63:0]   bram_rdata_i = '0;
  logic [63:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic          busy_o;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int beats_accepted = 0;
  int term_rises = 0;
  int last_hs_cycle = -10;
  int ready_mode = 1;  // 0: stalled, 1: always ready, 2: 30% random
  logic [64:0] exp_q[$];

  bram_dma_streamer #(
    .DEPTH(DEPTH),
    .AW(AW),
    .SYNC_STAGES(SS)
  ) dut (
    .axi_clk          (axi_clk),
    .rst_ni           (rst_ni),
    .dma_enable_i     (dma_enable_i),
    .dma_termination_o(dma_termination_o),
    .bram_addr_o      (bram_addr_o),
    .bram_rdata_i     (bram_rdata_i),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .busy_o           (busy_o)
  );

  always #5 axi_clk = ~axi_clk;

  // BRAM model: word i holds i, one cycle read latency.
  always @(posedge axi_clk) bram_rdata_i <= 64'(bram_addr_o);

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge axi_clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge axi_clk);
      #1;
      case (ready_mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = ($urandom_range(99) < 30);
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    logic        prev_stall;
    logic [63:0] prev_data;
    logic        prev_last;
    logic        prev_term;
    logic [64:0] exp;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    prev_term  = 1'b0;
    forever begin
      @(negedge axi_clk);
      cycle++;
      if (!rst_ni) begin
        prev_stall = 1'b0;
        prev_term  = 1'b0;
      end else begin
        if (prev_stall && m_axis_tvalid) begin
          check_eq("tdata_stable", m_axis_tdata, prev_data);
          check_eq("tlast_stable", 64'(m_axis_tlast), 64'(prev_last));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          beats_accepted++;
          $display("beat %0d: data=%0h last=%0b", beats_accepted, m_axis_tdata, m_axis_tlast);
          check_eq("beat_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check_eq("beat_data", m_axis_tdata, exp[63:0]);
            check_eq("beat_last", 64'(m_axis_tlast), 64'(exp[64]));
          end
          if (m_axis_tlast) last_hs_cycle = cycle;
        end
        if (dma_termination_o && !prev_term) begin
          term_rises++;
          check_eq("term_rise_timing", 64'(cycle), 64'(last_hs_cycle + 1));
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
        prev_term  = dma_termination_o;
      end
    end
  end

  task automatic start_capture();
    dma_enable_i = 1'b0;
    tick(4);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({(i == DEPTH - 1), 64'(i)});
    dma_enable_i = 1'b1;
  endtask

  task automatic wait_beats(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (beats_accepted < target && n < budget) begin
      tick(1);
      n++;
    end
    check_eq(name, 64'(beats_accepted >= target), 64'd1);
  endtask

  task automatic stop_capture();
    dma_enable_i = 1'b0;
    tick(SS + 2);
    check_eq("idle_after_stop", 64'(busy_o), 64'd0);
    check_eq("term_low_after_stop", 64'(dma_termination_o), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    check_eq({tag, "_tlast"}, 64'(m_axis_tlast), 64'd0);
    check_eq({tag, "_tdata"}, m_axis_tdata, 64'd0);
    check_eq({tag, "_addr"}, 64'(bram_addr_o), 64'd0);
    check_eq({tag, "_term"}, 64'(dma_termination_o), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    int base;
    int rises;
    logic got;

    // Reset state
    tick(3);
    check_outputs_zero("reset");
    rst_ni = 1'b1;
    tick(2);

    // Test 1: always ready, back-to-back beats, termination hold and release
    ready_mode = 1;
    rises = term_rises;
    start_capture();
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge axi_clk);
      got = m_axis_tvalid;
    end
    check_eq("first_tvalid", 64'(got), 64'd1);
    for (int k = 0; k < DEPTH; k++) begin
      check_eq("back_to_back", 64'(m_axis_tvalid && m_axis_tready), 64'd1);
      @(negedge axi_clk);
    end
    check_eq("no_extra_tvalid", 64'(m_axis_tvalid), 64'd0);
    tick(10);
    check_eq("term_held", 64'(dma_termination_o), 64'd1);
    check_eq("term_rise_count", 64'(term_rises), 64'(rises + 1));
    check_eq("queue_empty_t1", 64'(exp_q.size()), 64'd0);
    dma_enable_i = 1'b0;
    tick(SS);
    check_eq("term_still_high", 64'(dma_termination_o), 64'd1);
    tick(1);
    check_eq("term_fall", 64'(dma_termination_o), 64'd0);
    check_eq("busy_fall", 64'(busy_o), 64'd0);

    // Test 2: 30% random ready
    ready_mode = 2;
    rises = term_rises;
    base = beats_accepted;
    start_capture();
    wait_beats(base + DEPTH, 600, "random_ready_complete");
    tick(2);
    check_eq("queue_empty_t2", 64'(exp_q.size()), 64'd0);
    check_eq("term_rise_t2", 64'(term_rises), 64'(rises + 1));
    stop_capture();

    // Test 3: long stall after first tvalid
    ready_mode = 0;
    base = beats_accepted;
    start_capture();
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge axi_clk);
      got = m_axis_tvalid;
    end
    check_eq("stall_first_tvalid", 64'(got), 64'd1);
    tick(50);
    check_eq("stall_no_beats", 64'(beats_accepted), 64'(base));
    check_eq("stall_reads_ahead", 64'(bram_addr_o), 64'd2);
    ready_mode = 1;
    wait_beats(base + DEPTH, 100, "stall_resume_complete");
    tick(2);
    check_eq("queue_empty_t3", 64'(exp_q.size()), 64'd0);
    stop_capture();

    // Test 4: abort at beat 7, then restart from address 0
    ready_mode = 1;
    rises = term_rises;
    base = beats_accepted;
    start_capture();
    wait_beats(base + 8, 100, "abort_reach_beat7");
    dma_enable_i = 1'b0;
    tick(SS);
    check_eq("abort_busy_before", 64'(busy_o), 64'd1);
    check_eq("abort_tvalid_before", 64'(m_axis_tvalid), 64'd1);
    tick(1);
    check_eq("abort_tvalid_drop", 64'(m_axis_tvalid), 64'd0);
    check_eq("abort_idle", 64'(busy_o), 64'd0);
    exp_q.delete();
    tick(5);
    check_eq("abort_no_term", 64'(term_rises), 64'(rises));
    check_eq("abort_term_low", 64'(dma_termination_o), 64'd0);
    base = beats_accepted;
    start_capture();
    wait_beats(base + DEPTH, 100, "restart_complete");
    tick(2);
    check_eq("queue_empty_t4", 64'(exp_q.size()), 64'd0);
    stop_capture();

    // Test 5: reset mid-stream, enable held across reset
    base = beats_accepted;
    start_capture();
    wait_beats(base + 5, 100, "reset_reach_beat5");
    #2;
    rst_ni = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    tick(2);
    rst_ni = 1'b1;
    base = beats_accepted;
    tick(20);
    check_eq("post_reset_no_beats", 64'(beats_accepted), 64'(base));
    check_eq("post_reset_idle", 64'(busy_o), 64'd0);
    check_eq("post_reset_tvalid", 64'(m_axis_tvalid), 64'd0);
    start_capture();
    wait_beats(base + DEPTH, 100, "post_reset_complete");
    tick(2);
    check_eq("queue_empty_t5", 64'(exp_q.size()), 64'd0);
    stop_capture();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
